// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/bypass scoreboard: the per-stage
// destination entry, the regfile select code and the bubble entry.
package hazard_pkg;

  // Widest register index an entry can hold; narrower indices are zero-extended.
  localparam int RD_W = 8;

  localparam int SEL_REGFILE = 0;

  typedef struct packed {
    logic            valid;
    logic [RD_W-1:0] rd;
    logic            we;
    logic            is_load;
  } entry_t;

  localparam entry_t BUBBLE = '0;

  // Only live, writing, non-r0 entries can produce a hazard.
  function automatic logic entry_matches(entry_t e, logic [RD_W-1:0] src);
    return e.valid && e.we && (e.rd != '0) && (e.rd == src);
  endfunction

endpackage : hazard_pkg

// File: rtl/hazard_scoreboard_if.sv
// Decode-side interface of the hazard scoreboard: the pipeline (master)
// presents decode info, flush and hold; the scoreboard (slave) returns stall and bypass selects.
interface hazard_scoreboard_if #(
  parameter int REG_BITS = 5,
  parameter int DEPTH    = 3
);
  localparam int SELW = $clog2(DEPTH + 1);

  logic                id_valid;
  logic [REG_BITS-1:0] id_rs;
  logic [REG_BITS-1:0] id_rt;
  logic                id_rs_used;
  logic                id_rt_used;
  logic [REG_BITS-1:0] id_rd;
  logic                id_we;
  logic                id_is_load;
  logic                flush;
  logic                hold;
  logic                stall;
  logic [SELW-1:0]     byp_a;
  logic [SELW-1:0]     byp_b;
  logic [31:0]         stall_cnt;
  logic [31:0]         flush_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
           id_rd, id_we, id_is_load, flush, hold,
    input  stall, byp_a, byp_b, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
           id_rd, id_we, id_is_load, flush, hold,
    output stall, byp_a, byp_b, stall_cnt, flush_cnt
  );

endinterface : hazard_scoreboard_if

// File: rtl/hazard_match.sv
// Youngest-match priority encoder: returns k+1 for the smallest k whose entry
// writes the requested source register, plus whether that producer is a load.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  entry_t [DEPTH-1:0]              entries,
  input  logic   [RD_W-1:0]               src,
  input  logic                            used,
  output logic   [$clog2(DEPTH+1)-1:0]    sel,
  output logic                            is_load
);

  localparam int SELW = $clog2(DEPTH + 1);

  // NOTE: every output gets a default before the search, so no path through
  // this block leaves a value held and no latch is inferred.
  always_comb begin
    sel     = SELW'(SEL_REGFILE);
    is_load = 1'b0;
    if (used) begin
      // Walk oldest to youngest so the youngest match overwrites older ones.
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (entry_matches(entries[k], src)) begin
          sel     = SELW'(k + 1);
          is_load = entries[k].is_load;
        end
      end
    end
  end

endmodule : hazard_match

// File: rtl/hazard_scoreboard.sv
// Hazard/bypass controller: DEPTH-entry destination scoreboard shifting with the
// pipeline; reset is asynchronous active-low. Counters built only with HAZARD_PERF_EN.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_BITS   = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2
) (
  input logic                 clock,
  input logic                 reset,
  hazard_scoreboard_if.slave  bus
);

  localparam int SELW = $clog2(DEPTH + 1);

  entry_t [DEPTH-1:0] entries;
  logic [SELW-1:0]    sel_a, sel_b;
  logic [SELW-1:0]    byp_a_q, byp_b_q;
  logic               ld_a, ld_b;
  logic               load_use;
  logic [REG_BITS-1:0] rs_idx, rt_idx, rd_idx;

  assign rs_idx = bus.id_rs;
  assign rt_idx = bus.id_rt;
  assign rd_idx = bus.id_rd;

  hazard_match #(.DEPTH(DEPTH)) u_match_a (
    .entries (entries),
    .src     (RD_W'(rs_idx)),
    .used    (bus.id_rs_used),
    .sel     (sel_a),
    .is_load (ld_a)
  );

  hazard_match #(.DEPTH(DEPTH)) u_match_b (
    .entries (entries),
    .src     (RD_W'(rt_idx)),
    .used    (bus.id_rt_used),
    .sel     (sel_b),
    .is_load (ld_b)
  );

  // A load whose data is not yet forwardable from its current stage forces a bubble.
  always_comb begin
    load_use = reset && bus.id_valid && !bus.flush && !bus.hold &&
               ((ld_a && (int'(sel_a) < LOAD_STAGE)) ||
                (ld_b && (int'(sel_b) < LOAD_STAGE)));
  end

  // Hold freezes PC and F/D as well; reset overrides everything.
  assign bus.stall = reset && (bus.hold || load_use);
  assign bus.byp_a = byp_a_q;
  assign bus.byp_b = byp_b_q;

  // NOTE: the entry array is reset like any other state; stale valid bits after
  // reset would otherwise raise phantom hazards and bypasses.
  // NOTE: non-blocking assignments throughout, so the shift reads pre-edge entries.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      entries <= '0;
      byp_a_q <= SELW'(SEL_REGFILE);
      byp_b_q <= SELW'(SEL_REGFILE);
    end else if (!bus.hold) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        entries[i] <= entries[i-1];
      end
      if (bus.flush || load_use) begin
        entries[0] <= BUBBLE;
        byp_a_q    <= SELW'(SEL_REGFILE);
        byp_b_q    <= SELW'(SEL_REGFILE);
      end else begin
        entries[0] <= '{valid:   bus.id_valid,
                        rd:      RD_W'(rd_idx),
                        we:      bus.id_we,
                        is_load: bus.id_is_load};
        byp_a_q    <= bus.id_valid ? sel_a : SELW'(SEL_REGFILE);
        byp_b_q    <= bus.id_valid ? sel_b : SELW'(SEL_REGFILE);
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (load_use)                stall_cnt_q <= stall_cnt_q + 32'd1;
      if (bus.flush && !bus.hold)  flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`else
  assign bus.stall_cnt = '0;
  assign bus.flush_cnt = '0;
`endif

endmodule : hazard_scoreboard

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard-driven bench for hazard_scoreboard: each test drives decode vectors,
// checks the combinational stall, and pops the expected bypass selects after the edge.
module tb_hazard_scoreboard;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  hazard_scoreboard_if #(.REG_BITS(5), .DEPTH(3)) bus ();

  hazard_scoreboard #(.REG_BITS(5), .DEPTH(3), .LOAD_STAGE(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic       v;
    logic [4:0] rs;
    logic       rsu;
    logic [4:0] rt;
    logic       rtu;
    logic [4:0] rd;
    logic       we, ld, fl, hd;
    logic       st;
    logic [1:0] a, b;
  } vec_t;

  logic [3:0] sb[$];
  int n_vec = 0;
  int n_bad = 0;

  function automatic vec_t mk(logic v, logic [4:0] rs, logic rsu, logic [4:0] rt, logic rtu,
                              logic [4:0] rd, logic we, logic ld, logic fl, logic hd,
                              logic st, logic [1:0] a, logic [1:0] b);
    vec_t s;
    s.v = v; s.rs = rs; s.rsu = rsu; s.rt = rt; s.rtu = rtu; s.rd = rd;
    s.we = we; s.ld = ld; s.fl = fl; s.hd = hd; s.st = st; s.a = a; s.b = b;
    return s;
  endfunction

  function automatic vec_t alu(logic [4:0] rd, logic [4:0] rs, logic [4:0] rt,
                               logic st, logic [1:0] a, logic [1:0] b);
    return mk(1, rs, 1, rt, 1, rd, 1, 0, 0, 0, st, a, b);
  endfunction

  function automatic vec_t lw(logic [4:0] rd, logic [4:0] rs, logic st, logic [1:0] a, logic [1:0] b);
    return mk(1, rs, 1, 5'd0, 0, rd, 1, 1, 0, 0, st, a, b);
  endfunction

  task automatic apply(input vec_t s);
    bus.id_valid = s.v;  bus.id_rs = s.rs;  bus.id_rs_used = s.rsu;
    bus.id_rt = s.rt;    bus.id_rt_used = s.rtu;
    bus.id_rd = s.rd;    bus.id_we = s.we;  bus.id_is_load = s.ld;
    bus.flush = s.fl;    bus.hold = s.hd;
    sb.push_back({s.a, s.b});
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.id_valid = 0; bus.id_rs = 0; bus.id_rs_used = 0; bus.id_rt = 0; bus.id_rt_used = 0;
    bus.id_rd = 0; bus.id_we = 0; bus.id_is_load = 0; bus.flush = 0; bus.hold = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    sb.delete();
    repeat (2) tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    bus.hold = 1; bus.id_valid = 1; bus.id_rs = 5'd3; bus.id_rs_used = 1;
    #2;
    n_vec++;
    if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %b want 0", bus.stall); end
    tick();
    n_vec++;
    if ({bus.byp_a, bus.byp_b} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_byp got %0d/%0d want 0/0", bus.byp_a, bus.byp_b);
    end
    n_vec++;
    if (bus.stall_cnt !== 32'd0 || bus.flush_cnt !== 32'd0) begin
      n_bad++; $display("FAIL reset_cnt got %0d/%0d want 0/0", bus.stall_cnt, bus.flush_cnt);
    end
  endtask

  task automatic test_alu_back_to_back();
    vec_t v[$];
    logic [3:0] exp;
    do_reset();
    v.push_back(alu(5'd3, 5'd1, 5'd2, 0, 0, 0));
    v.push_back(alu(5'd5, 5'd3, 5'd4, 0, 1, 0));
    v.push_back(mk(0, 5'd3, 1, 5'd5, 1, 5'd3, 1, 0, 0, 0, 0, 0, 0));
    foreach (v[i]) begin
      apply(v[i]); #1;
      n_vec++;
      if (bus.stall !== v[i].st) begin n_bad++; $display("FAIL alu_b2b[%0d] stall got %b want %b", i, bus.stall, v[i].st); end
      tick();
      exp = sb.pop_front(); n_vec++;
      if ({bus.byp_a, bus.byp_b} !== exp) begin
        n_bad++; $display("FAIL alu_b2b[%0d] byp got %0d/%0d want %0d/%0d", i, bus.byp_a, bus.byp_b, exp[3:2], exp[1:0]);
      end
    end
  endtask

  task automatic test_distance();
    vec_t v[$];
    logic [3:0] exp;
    do_reset();
    v.push_back(alu(5'd3, 5'd1, 5'd2, 0, 0, 0));
    v.push_back(mk(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0, 0, 0));
    v.push_back(alu(5'd6, 5'd1, 5'd3, 0, 0, 2));
    v.push_back(alu(5'd9, 5'd3, 5'd6, 0, 3, 1));
    foreach (v[i]) begin
      apply(v[i]); #1;
      n_vec++;
      if (bus.stall !== v[i].st) begin n_bad++; $display("FAIL distance[%0d] stall got %b want %b", i, bus.stall, v[i].st); end
      tick();
      exp = sb.pop_front(); n_vec++;
      if ({bus.byp_a, bus.byp_b} !== exp) begin
        n_bad++; $display("FAIL distance[%0d] byp got %0d/%0d want %0d/%0d", i, bus.byp_a, bus.byp_b, exp[3:2], exp[1:0]);
      end
    end
  endtask

  task automatic test_load_use();
    vec_t v[$];
    logic [3:0] exp;
    logic [31:0] exp_cnt;
    do_reset();
    v.push_back(lw(5'd7, 5'd1, 0, 0, 0));
    v.push_back(alu(5'd8, 5'd7, 5'd7, 1, 0, 0));
    v.push_back(alu(5'd8, 5'd7, 5'd7, 0, 2, 2));
    foreach (v[i]) begin
      apply(v[i]); #1;
      n_vec++;
      if (bus.stall !== v[i].st) begin n_bad++; $display("FAIL load_use[%0d] stall got %b want %b", i, bus.stall, v[i].st); end
      tick();
      exp = sb.pop_front(); n_vec++;
      if ({bus.byp_a, bus.byp_b} !== exp) begin
        n_bad++; $display("FAIL load_use[%0d] byp got %0d/%0d want %0d/%0d", i, bus.byp_a, bus.byp_b, exp[3:2], exp[1:0]);
      end
    end
`ifdef HAZARD_PERF_EN
    exp_cnt = 32'd1;
`else
    exp_cnt = 32'd0;
`endif
    n_vec++;
    if (bus.stall_cnt !== exp_cnt) begin n_bad++; $display("FAIL load_use_cnt got %0d want %0d", bus.stall_cnt, exp_cnt); end
  endtask

  task automatic test_reg0_youngest();
    vec_t v[$];
    logic [3:0] exp;
    do_reset();
    v.push_back(alu(5'd0, 5'd1, 5'd2, 0, 0, 0));
    v.push_back(alu(5'd4, 5'd1, 5'd2, 0, 0, 0));
    v.push_back(alu(5'd4, 5'd1, 5'd2, 0, 0, 0));
    v.push_back(alu(5'd5, 5'd0, 5'd4, 0, 0, 1));
    foreach (v[i]) begin
      apply(v[i]); #1;
      n_vec++;
      if (bus.stall !== v[i].st) begin n_bad++; $display("FAIL reg0_young[%0d] stall got %b want %b", i, bus.stall, v[i].st); end
      tick();
      exp = sb.pop_front(); n_vec++;
      if ({bus.byp_a, bus.byp_b} !== exp) begin
        n_bad++; $display("FAIL reg0_young[%0d] byp got %0d/%0d want %0d/%0d", i, bus.byp_a, bus.byp_b, exp[3:2], exp[1:0]);
      end
    end
  endtask

  task automatic test_flush_vs_stall();
    vec_t v[$];
    vec_t f;
    logic [3:0] exp;
    logic [31:0] exp_fcnt;
    do_reset();
    f = alu(5'd8, 5'd7, 5'd7, 0, 0, 0);
    f.fl = 1'b1;
    v.push_back(lw(5'd7, 5'd1, 0, 0, 0));
    v.push_back(f);
    v.push_back(alu(5'd9, 5'd7, 5'd8, 0, 2, 0));
    foreach (v[i]) begin
      apply(v[i]); #1;
      n_vec++;
      if (bus.stall !== v[i].st) begin n_bad++; $display("FAIL flush[%0d] stall got %b want %b", i, bus.stall, v[i].st); end
      tick();
      exp = sb.pop_front(); n_vec++;
      if ({bus.byp_a, bus.byp_b} !== exp) begin
        n_bad++; $display("FAIL flush[%0d] byp got %0d/%0d want %0d/%0d", i, bus.byp_a, bus.byp_b, exp[3:2], exp[1:0]);
      end
    end
`ifdef HAZARD_PERF_EN
    exp_fcnt = 32'd1;
`else
    exp_fcnt = 32'd0;
`endif
    n_vec++;
    if (bus.flush_cnt !== exp_fcnt) begin n_bad++; $display("FAIL flush_cnt got %0d want %0d", bus.flush_cnt, exp_fcnt); end
    n_vec++;
    if (bus.stall_cnt !== 32'd0) begin n_bad++; $display("FAIL flush_stall_cnt got %0d want 0", bus.stall_cnt); end
  endtask

  task automatic test_hold_reset();
    vec_t v[$];
    vec_t h;
    logic [3:0] exp;
    do_reset();
    h = alu(5'd9, 5'd3, 5'd2, 1, 1, 1);
    h.hd = 1'b1;
    v.push_back(alu(5'd2, 5'd1, 5'd1, 0, 0, 0));
    v.push_back(alu(5'd3, 5'd2, 5'd2, 0, 1, 1));
    repeat (5) v.push_back(h);
    v.push_back(alu(5'd9, 5'd3, 5'd2, 0, 1, 2));
    foreach (v[i]) begin
      apply(v[i]); #1;
      n_vec++;
      if (bus.stall !== v[i].st) begin n_bad++; $display("FAIL hold[%0d] stall got %b want %b", i, bus.stall, v[i].st); end
      tick();
      exp = sb.pop_front(); n_vec++;
      if ({bus.byp_a, bus.byp_b} !== exp) begin
        n_bad++; $display("FAIL hold[%0d] byp got %0d/%0d want %0d/%0d", i, bus.byp_a, bus.byp_b, exp[3:2], exp[1:0]);
      end
    end
    // Hold again with a live bypass, then pull reset between clock edges.
    bus.hold = 1'b1;
    #1;
    n_vec++;
    if (bus.stall !== 1'b1) begin n_bad++; $display("FAIL hold_pre_reset stall got %b want 1", bus.stall); end
    #2 reset = 1'b0;
    #1;
    n_vec++;
    if ({bus.stall, bus.byp_a, bus.byp_b} !== 5'b0) begin
      n_bad++; $display("FAIL async_reset got stall=%b byp=%0d/%0d want 0 0/0", bus.stall, bus.byp_a, bus.byp_b);
    end
    n_vec++;
    if (bus.stall_cnt !== 32'd0 || bus.flush_cnt !== 32'd0) begin
      n_bad++; $display("FAIL async_reset_cnt got %0d/%0d want 0/0", bus.stall_cnt, bus.flush_cnt);
    end
    tick();
    reset = 1'b1;
    sb.delete();
    apply(alu(5'd10, 5'd3, 5'd2, 0, 0, 0));
    #1;
    n_vec++;
    if (bus.stall !== 1'b0) begin n_bad++; $display("FAIL post_reset stall got %b want 0", bus.stall); end
    tick();
    exp = sb.pop_front(); n_vec++;
    if ({bus.byp_a, bus.byp_b} !== exp) begin
      n_bad++; $display("FAIL post_reset byp got %0d/%0d want %0d/%0d", bus.byp_a, bus.byp_b, exp[3:2], exp[1:0]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu_back_to_back();
    test_distance();
    test_load_use();
    test_reg0_youngest();
    test_flush_vs_stall();
    test_hold_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_hazard_scoreboard
